// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner: shows up to 8 hex nibbles, one digit per REFRESH_DIV clocks.
// Latency: anode/cathode/dp are registered and follow the digit index one clk later; inputs take effect at the next frame wrap.
// No backpressure: free-running scan. Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the highest nonzero nibble.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_DIGITS  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_in,
  output logic [7:0]  anode,
  output logic [6:0]  cathode,
  output logic        dp,
  output logic        frame_done
);

  // A refresh count of 1 still needs a 1-bit counter that simply stays at 0.
  localparam int            CW           = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST     = CW'(REFRESH_DIV - 1);
  localparam logic [2:0]    IDX_LAST     = 3'(NUM_DIGITS - 1);
  localparam logic [7:0]    PRESENT_MASK = 8'((9'd1 << NUM_DIGITS) - 9'd1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic          first;
  logic [31:0]   sh_value;
  logic [7:0]    sh_en;
  logic [7:0]    sh_dp;

  logic          cnt_tc;
  logic          idx_wrap;
  logic [3:0]    cur_nib;
  logic          lit;
  logic [7:0]    anode_nxt;
  logic [6:0]    cathode_nxt;
  logic          dp_nxt;

  assign cnt_tc   = (cnt == CNT_LAST);
  // Digit index wrap is an explicit compare so non-power-of-2 digit counts work.
  assign idx_wrap = cnt_tc && (idx == IDX_LAST);
  assign cur_nib  = sh_value[{idx, 2'b00} +: 4];

  // Standard active-low hex decode, segment order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Refresh counter and digit index: index steps once per REFRESH_DIV clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      if (cnt_tc) begin
        cnt <= '0;
        idx <= idx_wrap ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Shadow copies of the inputs, reloaded only at frame boundaries so a frame never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first    <= 1'b1;
      sh_value <= '0;
      sh_en    <= '0;
      sh_dp    <= '0;
    end else begin
      first <= 1'b0;
      if (first || idx_wrap) begin
        sh_value <= value;
        sh_en    <= digit_en;
        sh_dp    <= dp_in;
      end
    end
  end

  // Decide whether the current digit is lit and what it shows.
  always_comb begin
    lit = sh_en[idx];
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic [2:0] hi;
      hi = 3'd0;
      for (int k = 0; k < 8; k++) begin
        if ((k < NUM_DIGITS) && (sh_value[4*k +: 4] != 4'h0)) begin
          hi = 3'(k);
        end
      end
      // Digit 0 is always shown so a zero value still reads "0".
      if (idx > hi) begin
        lit = 1'b0;
      end
    end
`endif
    anode_nxt   = 8'hFF;
    cathode_nxt = 7'h7F;
    dp_nxt      = 1'b1;
    if (lit) begin
      anode_nxt   = ~(8'd1 << idx) | ~PRESENT_MASK;
      cathode_nxt = hex_to_seg(cur_nib);
      dp_nxt      = ~sh_dp[idx];
    end
  end

  // Registered display outputs and frame pulse; reset blanks the display immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode      <= 8'hFF;
      cathode    <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      anode      <= anode_nxt;
      cathode    <= cathode_nxt;
      dp         <= dp_nxt;
      frame_done <= idx_wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for the 7-segment scanner: two instances (8 and 3 digits, refresh 4) share random inputs.
// A per-edge reference model pushes expected outputs into queues; a monitor pops and compares each cycle.
// Mid-frame async reset is checked directly in the same cycle it is asserted.
module tb_seg7_scan_driver;

  localparam int R = 4;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] ca;
    logic       dp;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] value = '0;
  logic [7:0]  digit_en = '0;
  logic [7:0]  dp_in = '0;

  logic [7:0] anode8, anode3;
  logic [6:0] cathode8, cathode3;
  logic       dp8, dp3, fd8, fd3;

  exp_t q8[$];
  exp_t q3[$];
  int   errors = 0;
  int   checks = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state per instance: edges since release, latched frame inputs, current digit.
  int          m_n   [2];
  logic [31:0] m_sv  [2];
  logic [7:0]  m_se  [2];
  logic [7:0]  m_sd  [2];
  int          m_idx [2];

  seg7_scan_driver #(.REFRESH_DIV(R), .NUM_DIGITS(8)) u_dut8 (
    .clk(clk), .reset(reset), .value(value), .digit_en(digit_en), .dp_in(dp_in),
    .anode(anode8), .cathode(cathode8), .dp(dp8), .frame_done(fd8)
  );

  seg7_scan_driver #(.REFRESH_DIV(R), .NUM_DIGITS(3)) u_dut3 (
    .clk(clk), .reset(reset), .value(value), .digit_en(digit_en), .dp_in(dp_in),
    .anode(anode3), .cathode(cathode3), .dp(dp3), .frame_done(fd3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
    end
  endtask

  // What digit k of instance i should show, given its latched frame inputs.
  function automatic exp_t display(input int i, input int nd, input int k);
    exp_t        e;
    logic [31:0] v;
    bit          on;
    int          hi;
    v  = m_sv[i];
    on = m_se[i][k];
`ifdef LEADING_ZERO_BLANK_EN
    hi = 0;
    for (int j = 0; j < nd; j++) if (((v >> (4*j)) & 32'hF) != 0) hi = j;
    if (k > hi) on = 0;
`else
    hi = nd;
`endif
    e.fd = 1'b0;
    if (on) begin
      e.an = ~(8'd1 << k);
      e.ca = seg_tab[(v >> (4*k)) & 32'hF];
      e.dp = ~m_sd[i][k];
    end else begin
      e.an = 8'hFF;
      e.ca = 7'h7F;
      e.dp = 1'b1;
    end
    return e;
  endfunction

  task automatic model_edge(input int i, input int nd, output exp_t e);
    if (reset) begin
      e = '{an: 8'hFF, ca: 7'h7F, dp: 1'b1, fd: 1'b0};
      m_n[i] = 0; m_sv[i] = '0; m_se[i] = '0; m_sd[i] = '0; m_idx[i] = 0;
    end else begin
      m_n[i]++;
      e    = display(i, nd, m_idx[i]);
      e.fd = (m_n[i] % (R * nd)) == 0;
      if (m_n[i] == 1 || e.fd) begin
        m_sv[i] = value; m_se[i] = digit_en; m_sd[i] = dp_in;
      end
      m_idx[i] = (m_n[i] / R) % nd;
    end
  endtask

  // Stimulus-side: at each edge, predict the outputs that edge produces.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      model_edge(0, 8, e); q8.push_back(e);
      model_edge(1, 3, e); q3.push_back(e);
    end
  end

  // Monitor: sample just after each edge and compare with the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q8.size() == 0) chk("q8_empty", 32'd0, 32'd1);
      else begin
        e = q8.pop_front();
        chk("anode8", {24'd0, anode8}, {24'd0, e.an});
        chk("cathode8", {25'd0, cathode8}, {25'd0, e.ca});
        chk("dp8", {31'd0, dp8}, {31'd0, e.dp});
        chk("frame_done8", {31'd0, fd8}, {31'd0, e.fd});
      end
      if (q3.size() == 0) chk("q3_empty", 32'd0, 32'd1);
      else begin
        e = q3.pop_front();
        chk("anode3", {24'd0, anode3}, {24'd0, e.an});
        chk("cathode3", {25'd0, cathode3}, {25'd0, e.ca});
        chk("dp3", {31'd0, dp3}, {31'd0, e.dp});
        chk("frame_done3", {31'd0, fd3}, {31'd0, e.fd});
      end
    end
  end

  task automatic run(input int n, input bit jitter);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (jitter && ($urandom_range(0, 3) == 0)) begin
        value    = $urandom;
        dp_in    = 8'($urandom);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_anode", {24'd0, anode8}, 32'hFF);
    chk("rst_cathode", {25'd0, cathode8}, 32'h7F);
    chk("rst_dp", {31'd0, dp8}, 32'd1);
    value = 32'h0123_89AF; digit_en = 8'hFF; dp_in = 8'h00;
    reset = 1'b0;
    run(40, 0);
    value = 32'hFEDC_BA98;           // mid-frame change, visible from next frame only
    run(50, 0);
    digit_en = 8'h05; dp_in = 8'h04;
    run(70, 0);
    for (int it = 0; it < 8; it++) begin
      value    = $urandom;
      digit_en = 8'($urandom);
      dp_in    = 8'($urandom);
      run($urandom_range(10, 80), it[0]);
    end
    value = 32'h0000_0042; digit_en = 8'hFF; dp_in = 8'hFF;
    run(70, 0);
    value = 32'h0000_0000;
    run(70, 0);
    value = 32'h0000_0300;
    run(45, 0);
    reset = 1'b1;
    #1;
    chk("midrst_anode8", {24'd0, anode8}, 32'hFF);
    chk("midrst_anode3", {24'd0, anode3}, 32'hFF);
    chk("midrst_cathode8", {25'd0, cathode8}, 32'h7F);
    chk("midrst_dp8", {31'd0, dp8}, 32'd1);
    chk("midrst_fd8", {31'd0, fd8}, 32'd0);
    run(2, 0);
    value = 32'h7654_3210; digit_en = 8'hFF; dp_in = 8'h81;
    reset = 1'b0;
    run(80, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
